// File: rtl/sd_pkg.sv
// Shared constants and types for the SD CMD-line response path.
package sd_pkg;

  localparam logic [6:0] CRC7_POLY      = 7'h09;
  localparam int         RESP_SHORT_LEN = 48;
  localparam int         RESP_LONG_LEN  = 136;
  localparam int         NCR_MAX_DEF    = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    RX,
    DONE
  } rx_state_e;

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), one data bit per enabled clock, MSB first.
module sd_crc7_serial
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       bit_en,
  input  logic       data,
  output logic [6:0] crc
);

  logic fb;
  assign fb = crc[6] ^ data;

  always_ff @(posedge clk) begin
    if (rst || clear) crc <= '0;
    else if (bit_en)  crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  end

endmodule

// File: rtl/sd_cmd_resp_rx.sv
// SD CMD-line response receiver: start-bit detect, deserialise, CRC7 and framing check.
// Define SD_LONG_RESP_EN to accept 136-bit R2 responses (adds resp_long_data).
module sd_cmd_resp_rx
  import sd_pkg::*;
#(
  parameter int NCR_MAX = NCR_MAX_DEF,
  parameter int CNT_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bit_en,
  input  logic          cmd_in,
  input  logic          arm,
  input  logic          skip_crc,
  input  logic          resp_long,
  output logic          busy,
  output logic          resp_valid,
  output logic [5:0]    resp_index,
  output logic [31:0]   resp_arg,
  output logic [6:0]    resp_crc,
  output logic          crc_err,
  output logic          frame_err,
  output logic          timeout
`ifdef SD_LONG_RESP_EN
  ,
  output logic [119:0]  resp_long_data
`endif
);

`ifdef SD_LONG_RESP_EN
  localparam int SR_W = RESP_LONG_LEN;
`else
  localparam int SR_W = RESP_SHORT_LEN;
`endif
  localparam logic [CNT_W-1:0] NCR_LAST    = CNT_W'(NCR_MAX - 1);
  localparam logic [CNT_W-1:0] CRC_LO      = CNT_W'(8);
  localparam logic [CNT_W-1:0] LONG_CRC_HI = CNT_W'(127);
  localparam logic [CNT_W-1:0] SHORT_LEN   = CNT_W'(RESP_SHORT_LEN);
  localparam logic [CNT_W-1:0] LONG_LEN    = CNT_W'(RESP_LONG_LEN);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt, to_cnt, frame_len, bit_idx;
  logic [SR_W-1:0]  sr, nxt_sr;
  logic [6:0]       crc;
  logic [5:0]       rx_index;
  logic             rx_tx;
  logic             skip_q, long_q;
  logic             arm_ok, crc_feed, crc_win, done_rx, done_to;

`ifdef SD_LONG_RESP_EN
  always_ff @(posedge clk) begin
    if (rst)         long_q <= 1'b0;
    else if (arm_ok) long_q <= resp_long;
  end
`else
  logic unused_resp_long;
  assign unused_resp_long = resp_long;
  assign long_q           = 1'b0;
`endif

  // The frame MSB drops off the top of the shift register and is never consumed.
  logic unused_sr_msb;
  assign unused_sr_msb = sr[SR_W-1];

  assign nxt_sr    = {sr[SR_W-2:0], cmd_in};
  assign frame_len = long_q ? LONG_LEN : SHORT_LEN;
  // Position of the bit on the line this strobe, counted from the frame LSB.
  assign bit_idx   = frame_len - CNT_W'(1) - bit_cnt;
  assign crc_win   = (bit_idx >= CRC_LO) && (!long_q || bit_idx <= LONG_CRC_HI);

  always_comb begin
    rx_index = nxt_sr[45:40];
    rx_tx    = nxt_sr[46];
`ifdef SD_LONG_RESP_EN
    if (long_q) begin
      rx_index = nxt_sr[133:128];
      rx_tx    = nxt_sr[134];
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    arm_ok   = 1'b0;
    crc_feed = 1'b0;
    done_rx  = 1'b0;
    done_to  = 1'b0;
    case (state_q)
      IDLE: if (arm) begin
        arm_ok  = 1'b1;
        state_d = WAIT_START;
      end
      WAIT_START: if (bit_en) begin
        if (!cmd_in) begin
          crc_feed = crc_win;
          state_d  = RX;
        end else if (to_cnt == NCR_LAST) begin
          done_to = 1'b1;
          state_d = DONE;
        end
      end
      RX: if (bit_en) begin
        crc_feed = crc_win;
        if (bit_cnt == frame_len - CNT_W'(1)) begin
          done_rx = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (arm) begin
          arm_ok  = 1'b1;
          state_d = WAIT_START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == WAIT_START) || (state_q == RX);
  assign resp_valid = (state_q == DONE);

  sd_crc7_serial u_crc (
    .clk    (clk),
    .rst    (rst),
    .clear  (arm_ok),
    .bit_en (crc_feed),
    .data   (cmd_in),
    .crc    (crc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      sr         <= '0;
      skip_q     <= 1'b0;
      resp_index <= '0;
      resp_arg   <= '0;
      resp_crc   <= '0;
      crc_err    <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (arm_ok) begin
        skip_q     <= skip_crc;
        bit_cnt    <= '0;
        to_cnt     <= '0;
        sr         <= '0;
        resp_index <= '0;
        resp_arg   <= '0;
        resp_crc   <= '0;
        crc_err    <= 1'b0;
        frame_err  <= 1'b0;
        timeout    <= 1'b0;
      end
      if (state_q == WAIT_START && bit_en) begin
        if (!cmd_in) begin
          bit_cnt <= CNT_W'(1);
          sr      <= nxt_sr;
        end else begin
          to_cnt <= to_cnt + CNT_W'(1);
        end
      end
      if (state_q == RX && bit_en) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        sr      <= nxt_sr;
      end
      if (done_to) timeout <= 1'b1;
      // The end bit is still on cmd_in, so results come from nxt_sr.
      if (done_rx) begin
        resp_index <= rx_index;
        resp_arg   <= nxt_sr[39:8];
        resp_crc   <= nxt_sr[7:1];
        crc_err    <= !skip_q && (nxt_sr[7:1] != crc);
        frame_err  <= rx_tx || !nxt_sr[0];
      end
    end
  end

`ifdef SD_LONG_RESP_EN
  always_ff @(posedge clk) begin
    if (rst || arm_ok) resp_long_data <= '0;
    else if (done_rx)  resp_long_data <= long_q ? nxt_sr[127:8] : '0;
  end
`endif

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// Scoreboard bench for sd_cmd_resp_rx: expected responses queued at stimulus, compared on resp_valid.
module tb_sd_cmd_resp_rx;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         bit_en = 1'b0;
  logic         cmd_in = 1'b1;
  logic         arm = 1'b0;
  logic         skip_crc = 1'b0;
  logic         resp_long = 1'b0;
  logic         busy, resp_valid, crc_err, frame_err, timeout;
  logic [5:0]   resp_index;
  logic [31:0]  resp_arg;
  logic [6:0]   resp_crc;
`ifdef SD_LONG_RESP_EN
  logic [119:0] resp_long_data;
  logic [119:0] ldat_q[$];
`endif

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        ce;
    logic        fe;
    logic        to;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t obs_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   obs_cyc = 0;
  int   strobe_cyc = 0;

  sd_cmd_resp_rx #(.NCR_MAX(64), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .cmd_in     (cmd_in),
    .arm        (arm),
    .skip_crc   (skip_crc),
    .resp_long  (resp_long),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_index (resp_index),
    .resp_arg   (resp_arg),
    .resp_crc   (resp_crc),
    .crc_err    (crc_err),
    .frame_err  (frame_err),
    .timeout    (timeout)
`ifdef SD_LONG_RESP_EN
    ,
    .resp_long_data (resp_long_data)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resp_valid) begin
      obs_q.push_back({resp_index, resp_arg, resp_crc, crc_err, frame_err, timeout});
      obs_cyc = cyc;
`ifdef SD_LONG_RESP_EN
      ldat_q.push_back(resp_long_data);
`endif
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] crc7(input logic [135:0] f, input int hi, input int lo);
    logic [6:0] c = 7'h00;
    logic       fb;
    for (int i = hi; i >= lo; i--) begin
      fb = c[6] ^ f[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  task automatic do_arm(input logic s, input logic l);
    @(negedge clk);
    arm = 1'b1; skip_crc = s; resp_long = l;
    @(negedge clk);
    arm = 1'b0; skip_crc = 1'b0; resp_long = 1'b0;
  endtask

  // Sends f[len-1] down to f[len-nsend]; optionally pulses arm (skip_crc=1) after strobe arm_at.
  task automatic send_frame(input logic [135:0] f, input int len, input int nsend, input int arm_at);
    for (int i = 0; i < nsend; i++) begin
      @(negedge clk);
      cmd_in = f[len-1-i]; bit_en = 1'b1; strobe_cyc = cyc;
      @(negedge clk);
      bit_en = 1'b0; cmd_in = 1'b1;
      if (i == arm_at) begin arm = 1'b1; skip_crc = 1'b1; end
      @(negedge clk);
      arm = 1'b0; skip_crc = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_idle(input int n);
    logic [135:0] ones = '1;
    send_frame(ones, 136, n, -1);
  endtask

  task automatic wait_obs(output bit got);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (obs_q.size() != 0) begin got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, resp_valid, resp_index, resp_arg, resp_crc, crc_err, frame_err, timeout} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b vld=%b idx=%h arg=%h crc=%h ce=%b fe=%b to=%b want all 0",
               busy, resp_valid, resp_index, resp_arg, resp_crc, crc_err, frame_err, timeout);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_r7_good;
    rsp_t e, o; bit got;
    do_arm(1'b0, 1'b0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_arm: got %b want 1", busy); end
    exp_q.push_back({6'h08, 32'h000001AA, 7'h09, 1'b0, 1'b0, 1'b0});
    send_idle(5);
    send_frame(136'h08000001AA13, 48, 48, -1);
    wait_obs(got);
    e = exp_q.pop_front();
    total++;
    if (!got) begin bad++; $display("FAIL r7_good: no resp_valid, want %h", e); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin bad++; $display("FAIL r7_good: got %h want %h", o, e); end
      total++;
      if (obs_cyc - strobe_cyc !== 1) begin
        bad++; $display("FAIL r7_latency: got %0d clk want 1", obs_cyc - strobe_cyc);
      end
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_after_done: got %b want 0", busy); end
    repeat (4) @(negedge clk);
    total++;
    if (resp_arg !== 32'h000001AA) begin bad++; $display("FAIL r7_hold: got %h want 000001aa", resp_arg); end
  endtask

  task automatic test_r7_bad_crc;
    rsp_t e, o; bit got;
    do_arm(1'b0, 1'b0);
    exp_q.push_back({6'h08, 32'h000001AA, 7'h0A, 1'b1, 1'b0, 1'b0});
    send_idle(2);
    send_frame(136'h08000001AA15, 48, 48, -1);
    wait_obs(got);
    e = exp_q.pop_front();
    total++;
    if (!got) begin bad++; $display("FAIL r7_bad_crc: no resp_valid, want %h", e); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin bad++; $display("FAIL r7_bad_crc: got %h want %h", o, e); end
    end
  endtask

  task automatic test_r3_skip;
    rsp_t e, o; bit got;
    do_arm(1'b1, 1'b0);
    total++;
    if (crc_err !== 1'b0) begin bad++; $display("FAIL arm_clears_flags: got crc_err=%b want 0", crc_err); end
    exp_q.push_back({6'h3F, 32'h00FF8000, 7'h7F, 1'b0, 1'b0, 1'b0});
    send_idle(1);
    send_frame(136'h3F00FF8000FF, 48, 48, -1);
    wait_obs(got);
    e = exp_q.pop_front();
    total++;
    if (!got) begin bad++; $display("FAIL r3_skip: no resp_valid, want %h", e); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin bad++; $display("FAIL r3_skip: got %h want %h", o, e); end
    end
  endtask

  task automatic test_frame_err;
    logic [135:0] fr[2];
    rsp_t         ex[2];
    rsp_t e, o; bit got;
    fr[0] = 136'h08000001AA12;   // end bit 0, CRC intact
    fr[1] = 136'h48000001AA13;   // transmission bit 1, CRC now wrong
    ex[0] = {6'h08, 32'h000001AA, 7'h09, 1'b0, 1'b1, 1'b0};
    ex[1] = {6'h08, 32'h000001AA, 7'h09, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      do_arm(1'b0, 1'b0);
      exp_q.push_back(ex[k]);
      send_frame(fr[k], 48, 48, -1);
      wait_obs(got);
      e = exp_q.pop_front();
      total++;
      if (!got) begin bad++; $display("FAIL frame_err_%0d: no resp_valid, want %h", k, e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL frame_err_%0d: got %h want %h", k, o, e); end
      end
    end
  endtask

  task automatic test_timeout;
    rsp_t e, o; bit got;
    do_arm(1'b0, 1'b0);
    send_idle(63);
    total++;
    if (obs_q.size() !== 0 || busy !== 1'b1) begin
      bad++; $display("FAIL timeout_early: got %0d responses busy=%b want 0 responses busy=1", obs_q.size(), busy);
      obs_q.delete();
    end
    exp_q.push_back({6'h00, 32'h0, 7'h00, 1'b0, 1'b0, 1'b1});
    send_idle(1);
    wait_obs(got);
    e = exp_q.pop_front();
    total++;
    if (!got) begin bad++; $display("FAIL timeout: no resp_valid, want %h", e); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin bad++; $display("FAIL timeout: got %h want %h", o, e); end
    end
  endtask

  task automatic test_rst_midframe;
    do_arm(1'b0, 1'b0);
    send_frame(136'h08000001AA13, 48, 20, -1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    total++;
    if ({busy, resp_valid, resp_index, resp_arg, resp_crc, crc_err, frame_err, timeout} !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got busy=%b vld=%b idx=%h arg=%h crc=%h ce=%b fe=%b to=%b want all 0",
               busy, resp_valid, resp_index, resp_arg, resp_crc, crc_err, frame_err, timeout);
    end
    send_frame(136'h0, 48, 30, -1);
    total++;
    if (obs_q.size() !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid_no_resp: got %0d responses busy=%b want 0 responses busy=0", obs_q.size(), busy);
      obs_q.delete();
    end
  endtask

  task automatic test_back_to_back;
    logic [135:0] a, b;
    rsp_t e, o; bit got;
    a = '0; a[45:40] = 6'h11; a[39:8] = 32'hCAFEF00D; a[7:1] = crc7(a, 47, 8); a[0] = 1'b1;
    b = '0; b[45:40] = 6'h29; b[39:8] = 32'h12345678; b[7:1] = ~crc7(b, 47, 8); b[0] = 1'b1;
    do_arm(1'b0, 1'b0);
    exp_q.push_back({a[45:40], a[39:8], a[7:1], 1'b0, 1'b0, 1'b0});
    send_frame(a, 48, 48, 47);       // re-arm (skip_crc=1) in the resp_valid cycle
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_rearm: got busy=%b want 1", busy); end
    wait_obs(got);
    e = exp_q.pop_front();
    total++;
    if (!got) begin bad++; $display("FAIL b2b_first: no resp_valid, want %h", e); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin bad++; $display("FAIL b2b_first: got %h want %h", o, e); end
    end
    exp_q.push_back({b[45:40], b[39:8], b[7:1], 1'b0, 1'b0, 1'b0});
    send_frame(b, 48, 48, -1);
    wait_obs(got);
    e = exp_q.pop_front();
    total++;
    if (!got) begin bad++; $display("FAIL b2b_second: no resp_valid, want %h", e); end
    else begin
      o = obs_q.pop_front();
      if (o !== e) begin bad++; $display("FAIL b2b_second: got %h want %h", o, e); end
    end
  endtask

  task automatic test_random;
    logic [135:0] f;
    rsp_t e, o; bit got;
    for (int k = 0; k < 3; k++) begin
      f = '0;
      f[45:40] = 6'($urandom_range(0, 63));
      f[39:8]  = $urandom;
      f[7:1]   = crc7(f, 47, 8);
      f[0]     = 1'b1;
      do_arm(1'b0, 1'b0);
      exp_q.push_back({f[45:40], f[39:8], f[7:1], 1'b0, 1'b0, 1'b0});
      send_idle($urandom_range(0, 3));
      send_frame(f, 48, 48, -1);
      wait_obs(got);
      e = exp_q.pop_front();
      total++;
      if (!got) begin bad++; $display("FAIL random_%0d: no resp_valid, want %h", k, e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin bad++; $display("FAIL random_%0d: got %h want %h", k, o, e); end
      end
    end
  endtask

`ifdef SD_LONG_RESP_EN
  task automatic test_long;
    logic [135:0] f;
    logic [127:0] rnd;
    logic [119:0] le, lo;
    rsp_t o; bit got;
    rnd = {$urandom, $urandom, $urandom, $urandom};
    f = '0;
    f[133:128] = 6'h3F;
    f[127:8]   = rnd[119:0];
    f[7:1]     = crc7(f, 127, 8);
    f[0]       = 1'b1;
    ldat_q.delete();
    do_arm(1'b0, 1'b1);
    send_idle(2);
    send_frame(f, 136, 136, 60);     // stray arm mid-frame must be ignored
    wait_obs(got);
    le = f[127:8];
    total++;
    if (!got) begin bad++; $display("FAIL long_r2: no resp_valid"); end
    else begin
      o  = obs_q.pop_front();
      lo = ldat_q.pop_front();
      if (lo !== le || o.ce !== 1'b0 || o.fe !== 1'b0 || o.to !== 1'b0 || o.crc !== f[7:1]) begin
        bad++;
        $display("FAIL long_r2: got data=%h ce=%b fe=%b to=%b crc=%h want data=%h ce=0 fe=0 to=0 crc=%h",
                 lo, o.ce, o.fe, o.to, o.crc, le, f[7:1]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_r7_good();
    test_r7_bad_crc();
    test_r3_skip();
    test_frame_err();
    test_timeout();
    test_rst_midframe();
    test_back_to_back();
    test_random();
`ifdef SD_LONG_RESP_EN
    test_long();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_cmd_resp_rx.md
Name: sd_cmd_resp_rx

Overview:
- SD-card CMD-line response receiver and checker.
- Samples the serial CMD line once per SD bit strobe and detects the start bit.
- Deserialises the response (48-bit R1/R3/R6/R7; optionally 136-bit R2), computes CRC7 bit-serially and checks it.
- Sits beside the command CRC7 generator in the SD host: commands go out, and this block validates what comes back before the host FSM consumes it.

Parameters:
- NCR_MAX, 64, max bit strobes between arm and start bit before timeout.
- CNT_W, 8, width of bit/timeout counters; must hold max(NCR_MAX, 136).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- bit_en  in  1  one-clk strobe; cmd_in sampled only when high.
- cmd_in  in  1  serial CMD line, MSB first.
- arm  in  1  one-clk pulse: start listening for a response.
- skip_crc  in  1  latched at arm; 1 = ignore CRC (R3).
- resp_long  in  1  latched at arm; 1 = 136-bit R2 (needs macro, else ignored).
- busy  out  1  high from accepted arm until resp_valid.
- resp_valid  out  1  one-clk completion pulse.
- resp_index  out  6  bits [45:40].
- resp_arg  out  32  bits [39:8].
- resp_crc  out  7  received bits [7:1].
- crc_err  out  1  received CRC != computed CRC (forced 0 if skip_crc).
- frame_err  out  1  transmission bit != 0 or end bit != 1.
- timeout  out  1  no start bit within NCR_MAX strobes.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; CRC register 0.
- FSM states: IDLE, WAIT_START, RX, DONE.
- IDLE -> WAIT_START on arm: latch skip_crc/resp_long, clear counters and CRC, set busy. arm while busy is ignored.
- WAIT_START:
  - On each bit_en: cmd_in=0 is the start bit; feed it to the CRC and go to RX with bit count 1.
  - Otherwise increment the timeout counter.
  - When the counter reaches NCR_MAX, go to DONE with timeout=1.
- RX: on each bit_en, shift cmd_in into the shift register.
  - 48-bit frames: CRC fed for bits 47..8 (40 bits); bits 7..1 captured as resp_crc; bit 0 is the end bit.
  - Leaving RX: after the strobe that samples the last bit (bit count = 48, or 136), go to DONE.
- CRC7 serial update (polynomial x^7+x^3+1):
  - fb = crc[6] ^ bit.
  - crc = {crc[5:0],1'b0} ^ (fb ? 7'h09 : 0).
- DONE (one clk):
  - Outputs: resp_valid=1, busy=0, error flags updated, then IDLE.
  - Latency: resp_valid is asserted in the clk after the bit_en cycle that sampled the end bit.
- Data outputs and flags hold until the next accepted arm, which clears the flags.
- arm in the DONE/resp_valid cycle is accepted (busy already low).
- bit_en with no arm pending (IDLE) has no effect.
- rst mid-frame: abort immediately, no resp_valid, outputs return to reset values.
- rst and arm in the same cycle: rst wins.
- Timeout response: resp_index/resp_arg/resp_crc = 0; crc_err=0, frame_err=0.

Optional Feature:
- Macro: SD_LONG_RESP_EN.
- Defined:
  - resp_long honoured; frame is 136 bits.
  - CRC runs over bits 127..8; bits 133..128 are reserved (check not required).
  - Extra output port resp_long_data [119:0] carries bits 127..8.
  - frame_err checks transmission bit and end bit as for 48-bit frames.
- Undefined:
  - resp_long ignored; resp_long_data absent; shift register is 48 bits.

Decomposition:
- Package sd_pkg:
  - CRC7_POLY = 7'h09.
  - RESP_SHORT_LEN = 48, RESP_LONG_LEN = 136.
  - FSM state typedef.
  - Default NCR_MAX.
- One sub-module, sd_crc7_serial: clear, bit_en, data bit, 7-bit crc out. Reusable for bit-serial command-side checking.

Test Plan:
- R7 frame 0x08_000001AA_13 after 5 idle-high strobes -> resp_valid, index=8, arg=0x000001AA, crc=0x09, crc_err=0, frame_err=0.
- Same frame with last byte 0x15 -> resp_crc=0x0A, crc_err=1, frame_err=0.
- R3 frame 0x3F_00FF8000_FF with skip_crc=1 -> index=0x3F, arg=0x00FF8000, crc_err=0, frame_err=0.
- arm, CMD held high for NCR_MAX=64 strobes -> resp_valid with timeout=1, all data outputs 0.
- R7 frame with end bit 0 -> frame_err=1; separately, rst asserted at bit 20 -> no resp_valid, busy=0, outputs 0.
- (SD_LONG_RESP_EN) arm with resp_long=1 and a 136-bit R2 with valid CRC -> resp_long_data matches the driven bits 127..8, crc_err=0; a second arm pulse during RX is ignored.
